// File: rtl/pe_sequencer.sv
// pe_sequencer: nested phase / tap / output-position index generator for the
// convolution PE array, with start/done handshake and accumulator strobes.
// Optional feature macro: PE_SEQ_STALL_EN (enables the stall input; when the
// macro is undefined, stall is ignored and every RUN cycle advances).
// Parameter constraints: PHASES >= 2, STRIDE >= 1, OUT >= 2, TAPS >= 2.
`timescale 1ns/1ps
module pe_sequencer #(
  parameter int IMG     = 14,
  parameter int KER     = 5,
  parameter int CHANNEL = 6,
  parameter int PHASES  = 4,
  parameter int STRIDE  = 1,
  localparam int OUT    = (IMG - KER) / STRIDE + 1,
  localparam int TAPS   = CHANNEL * KER,
  localparam int PW     = $clog2(PHASES),
  localparam int KW     = $clog2(TAPS),
  localparam int OW     = $clog2(OUT),
  localparam int IW     = OW + $clog2(STRIDE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] phase,
  output logic [KW-1:0] tap,
  output logic [OW-1:0] out_col,
  output logic [OW-1:0] out_row,
  output logic [IW-1:0] in_col,
  output logic [IW-1:0] in_row,
  output logic          acc_clr,
  output logic          acc_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [PW-1:0] PH_MAX  = PW'(PHASES - 1);
  localparam logic [KW-1:0] TAP_MAX = KW'(TAPS - 1);
  localparam logic [OW-1:0] POS_MAX = OW'(OUT - 1);
  localparam logic [IW-1:0] STEP    = IW'(STRIDE);

  state_t        r_state;
  state_t        w_state_nxt;

  logic [PW-1:0] r_phase;
  logic [KW-1:0] r_tap;
  logic [OW-1:0] r_col;
  logic [OW-1:0] r_row;
  logic [IW-1:0] r_in_col;
  logic [IW-1:0] r_in_row;

  logic          w_stall;
  logic          w_adv;
  logic          w_ph_last;
  logic          w_tap_last;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_step_last;

`ifdef PE_SEQ_STALL_EN
  assign w_stall = stall;
`else
  // stall is kept on the port for a uniform interface but has no effect
  logic w_stall_unused;
  assign w_stall_unused = stall;
  assign w_stall        = 1'b0;
`endif

  assign w_adv       = (r_state == S_RUN) && !w_stall;
  assign w_ph_last   = (r_phase == PH_MAX);
  assign w_tap_last  = (r_tap == TAP_MAX);
  assign w_col_last  = (r_col == POS_MAX);
  assign w_row_last  = (r_row == POS_MAX);
  // last phase of the last tap: the cycle that finishes one output position
  assign w_step_last = w_ph_last && w_tap_last;

  assign phase   = r_phase;
  assign tap     = r_tap;
  assign out_col = r_col;
  assign out_row = r_row;
  assign in_col  = r_in_col;
  assign in_row  = r_in_row;

  // State register; synchronous reset returns to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and decoded status / accumulator strobes
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    acc_clr     = 1'b0;
    acc_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy      = 1'b1;
        acc_clr   = (r_phase == '0) && (r_tap == '0);
        acc_valid = w_adv && w_step_last;
        if (w_adv && w_step_last && w_col_last && w_row_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Nested counters: phase -> tap -> out_col -> out_row; input base
  // coordinates track the output position with an incremental STRIDE adder
  always_ff @(posedge clk) begin
    if (rst || (r_state != S_RUN)) begin
      r_phase  <= '0;
      r_tap    <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_in_col <= '0;
      r_in_row <= '0;
    end else if (w_adv) begin
      if (w_ph_last) begin
        r_phase <= '0;
        if (w_tap_last) begin
          r_tap <= '0;
          if (w_col_last) begin
            r_col    <= '0;
            r_in_col <= '0;
            if (w_row_last) begin
              r_row    <= '0;
              r_in_row <= '0;
            end else begin
              r_row    <= r_row + 1'b1;
              r_in_row <= r_in_row + STEP;
            end
          end else begin
            r_col    <= r_col + 1'b1;
            r_in_col <= r_in_col + STEP;
          end
        end else begin
          r_tap <= r_tap + 1'b1;
        end
      end else begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// Testbench for pe_sequencer: scoreboard of expected acc_clr / acc_valid /
// done events, popped by an independent monitor. Configuration IMG=7, KER=3,
// CHANNEL=2, PHASES=2, STRIDE=2 -> OUT=3, TAPS=6, 12 cycles per output,
// 108 RUN cycles per pass.
`timescale 1ns/1ps
module tb_pe_sequencer;

  localparam int T_IMG  = 7;
  localparam int T_KER  = 3;
  localparam int T_CH   = 2;
  localparam int T_PH   = 2;
  localparam int T_STR  = 2;
  localparam int T_OUT  = (T_IMG - T_KER) / T_STR + 1;
  localparam int T_TAPS = T_CH * T_KER;
  localparam int T_STEP = T_TAPS * T_PH;
  localparam int T_LEN  = T_OUT * T_OUT * T_STEP;
  localparam int PW     = $clog2(T_PH);
  localparam int KW     = $clog2(T_TAPS);
  localparam int OW     = $clog2(T_OUT);
  localparam int IW     = OW + $clog2(T_STR + 1);
  localparam int NOCUT  = 1 << 30;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stall;
  logic          busy;
  logic          done;
  logic [PW-1:0] phase;
  logic [KW-1:0] tap;
  logic [OW-1:0] out_col;
  logic [OW-1:0] out_row;
  logic [IW-1:0] in_col;
  logic [IW-1:0] in_row;
  logic          acc_clr;
  logic          acc_valid;

  pe_sequencer #(
    .IMG(T_IMG), .KER(T_KER), .CHANNEL(T_CH), .PHASES(T_PH), .STRIDE(T_STR)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(busy), .done(done), .phase(phase), .tap(tap),
    .out_col(out_col), .out_row(out_row), .in_col(in_col), .in_row(in_row),
    .acc_clr(acc_clr), .acc_valid(acc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = acc_clr, 1 = acc_valid, 2 = done
  typedef struct {
    int kind;
    int cyc;
    int row;
    int col;
    int bcnt;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_en   = 1'b0;

  // Monitor: pops the next expected event whenever the DUT shows one
  int  busy_cnt = 0;
  int  got_kind;
  int  exp_ph;
  int  exp_tap;
  bit  ok;
  ev_t m_e;
  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      if (rst) busy_cnt = 0;
      else if (busy) busy_cnt++;
      if (acc_clr || acc_valid || done) begin
        got_kind = done ? 2 : (acc_valid ? 1 : 0);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_event kind=%0d at cyc=%0d, required none", got_kind, cyc);
        end else begin
          m_e     = exp_q.pop_front();
          exp_ph  = (m_e.kind == 1) ? T_PH - 1 : 0;
          exp_tap = (m_e.kind == 1) ? T_TAPS - 1 : 0;
          ok = (got_kind == m_e.kind) && (cyc == m_e.cyc) &&
               (int'(phase) == exp_ph) && (int'(tap) == exp_tap) &&
               (int'(out_row) == m_e.row) && (int'(out_col) == m_e.col) &&
               (int'(in_row) == m_e.row * T_STR) && (int'(in_col) == m_e.col * T_STR) &&
               (busy == (m_e.kind != 2)) &&
               ((m_e.kind != 2) || (busy_cnt == m_e.bcnt));
          if (!ok) begin
            n_errors++;
            $display("FAIL event got kind=%0d cyc=%0d ph=%0d tap=%0d row=%0d col=%0d in_row=%0d in_col=%0d busy=%0d bcnt=%0d ; required kind=%0d cyc=%0d ph=%0d tap=%0d row=%0d col=%0d in_row=%0d in_col=%0d bcnt=%0d",
                     got_kind, cyc, phase, tap, out_row, out_col, in_row, in_col, busy, busy_cnt,
                     m_e.kind, m_e.cyc, exp_ph, exp_tap, m_e.row, m_e.col,
                     m_e.row * T_STR, m_e.col * T_STR, m_e.bcnt);
          end
          if (m_e.kind == 2) busy_cnt = 0;
        end
      end
    end
  end

  task automatic chk_idle(input string nm);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || acc_clr !== 1'b0 || acc_valid !== 1'b0 ||
        phase !== '0 || tap !== '0 || out_col !== '0 || out_row !== '0 ||
        in_col !== '0 || in_row !== '0) begin
      n_errors++;
      $display("FAIL %s got busy=%0d done=%0d clr=%0d vld=%0d ph=%0d tap=%0d col=%0d row=%0d icol=%0d irow=%0d, required all 0",
               nm, busy, done, acc_clr, acc_valid, phase, tap, out_col, out_row, in_col, in_row);
    end
  endtask

  // Push the expected events of one pass, then pulse start for one cycle.
  // Events at nominal RUN cycle > stall_k are delayed by the effective stall
  // length; events at or beyond cut_k are not expected (pass aborted).
  task automatic launch(input int stall_k, input int stall_n, input int cut_k);
    int  t0;
    int  sh;
    int  k;
    ev_t e;
    t0 = cyc;
`ifdef PE_SEQ_STALL_EN
    sh = stall_n;
`else
    sh = 0;
`endif
    for (int o = 0; o < T_OUT * T_OUT; o++) begin
      for (int v = 0; v < 2; v++) begin
        k = o * T_STEP + ((v == 1) ? T_STEP - 1 : 0);
        if (k < cut_k) begin
          e.kind = v;
          e.cyc  = t0 + 1 + k + ((k > stall_k) ? sh : 0);
          e.row  = o / T_OUT;
          e.col  = o % T_OUT;
          e.bcnt = 0;
          exp_q.push_back(e);
        end
      end
    end
    if (cut_k > T_LEN) begin
      e.kind = 2;
      e.cyc  = t0 + 1 + T_LEN + sh;
      e.row  = 0;
      e.col  = 0;
      e.bcnt = T_LEN + sh;
      exp_q.push_back(e);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout got done=0 after %0d cycles, required done=1", n);
    end
  endtask

  logic [PW+KW+2*OW+2*IW-1:0] snap;
  logic [PW+KW+2*OW+2*IW-1:0] now_v;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset_state");
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk_idle("idle_hold");

    // Pass 1: plain unstalled pass
    launch(-1, 0, NOCUT);
    wait_done(T_LEN + 50);
    @(negedge clk);
    chk_idle("after_pass1");

    // Pass 2: start pulsed during RUN and during DONE must not restart
    launch(-1, 0, NOCUT);
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(T_LEN + 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_idle("no_restart");
      @(negedge clk);
    end

    // Pass 3: stall held for 5 cycles mid-step at RUN cycle 20
    launch(20, 5, NOCUT);
    repeat (20) @(negedge clk);
    snap  = {phase, tap, out_col, out_row, in_col, in_row};
    stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 5) stall = 1'b0;
      now_v = {phase, tap, out_col, out_row, in_col, in_row};
      n_checks++;
`ifdef PE_SEQ_STALL_EN
      if (now_v !== snap) begin
        n_errors++;
        $display("FAIL stall_freeze cycle %0d got %h, required %h", i, now_v, snap);
      end
`else
      if (now_v === snap) begin
        n_errors++;
        $display("FAIL stall_ignored cycle %0d got %h, required a value other than %h", i, now_v, snap);
      end
`endif
    end
    wait_done(T_LEN + 50);
    @(negedge clk);
    chk_idle("after_stall_pass");

    // Pass 4: reset at RUN cycle 50, then a full pass
    launch(-1, 0, 50);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("reset_mid_run");
    launch(-1, 0, NOCUT);
    wait_done(T_LEN + 50);
    @(negedge clk);
    chk_idle("after_pass5");

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got %0d pending events, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
